// File: rtl/npc_pipe_pkg.sv
// npc_pipe_pkg: shared widths, NOP encoding and occupancy states for NPC pipeline stage registers
package npc_pipe_pkg;
  localparam int XLEN = 32;
  localparam int IFID_W = 64;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_e;
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with 2-entry skid, flush and bubble payload; PIPE_STAGE_PERF_EN adds stall/flush counters
module pipe_stage_reg
  import npc_pipe_pkg::*;
#(
  parameter int DATA_W = IFID_W,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'({{(IFID_W-XLEN){1'b0}}, NOP_INSTR})
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef PIPE_STAGE_PERF_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
`endif
  output logic [DATA_W-1:0] out_data
);
  occ_e state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
  logic in_fire, out_fire;
  assign out_valid = state_q != EMPTY;
  assign in_ready = state_q != FULL;
  assign out_data = out_valid ? main_q : BUBBLE_DATA;
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  always_comb begin
    state_d = state_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (in_fire) begin
          state_d = ONE;
          main_d = in_data;
        end
        ONE: begin
          state_d = in_fire ? (out_fire ? ONE : FULL) : (out_fire ? EMPTY : ONE);
          main_d = (in_fire & out_fire) ? in_data : main_q;
          skid_d = (in_fire & !out_fire) ? in_data : skid_q;
        end
        FULL: if (out_fire) begin
          state_d = ONE;
          main_d = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q <= BUBBLE_DATA;
      skid_q <= BUBBLE_DATA;
    end else begin
      state_q <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    stall_cnt_d = stall_cnt_q + 32'(out_valid & !out_ready);
    flush_cnt_d = flush_cnt_q + 32'(flush & (state_q != EMPTY));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif
endmodule
